// File: rtl/microwave_timer_if.sv
//------------------------------------------------------------------------------
// Module   : microwave_timer_if
// Brief    : Keypad / magnetron / display bundle between the microwave
//            controller side and the countdown timer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface microwave_timer_if;
  logic       clearn;       // keypad CLEAR, active low
  logic [3:0] digit;        // BCD keypad digit
  logic       digit_valid;  // one-cycle strobe qualifying digit
  logic       mag_on;       // magnetron enable from the control block
  logic       timer_done;   // time expired (level)
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       beep;         // end-of-cook beeper

  // Controller / keypad side
  modport master (
    output clearn, digit, digit_valid, mag_on,
    input  timer_done, min_tens, min_ones, sec_tens, sec_ones, beep
  );

  // Timer side
  modport slave (
    input  clearn, digit, digit_valid, mag_on,
    output timer_done, min_tens, min_ones, sec_tens, sec_ones, beep
  );
endinterface

`default_nettype wire

// File: rtl/microwave_timer.sv
//------------------------------------------------------------------------------
// Module   : microwave_timer
// Brief    : Four-digit BCD mm:ss countdown timer. Digits are shifted in from
//            the keypad, decremented once per TICK_DIV clocks while the
//            magnetron runs, and timer_done is raised on reaching 00:00.
//            Optional end-of-cook beeper enabled by defining TIMER_BEEP_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module microwave_timer #(
  parameter int TICK_DIV   = 100,  // clock cycles per one-second tick (>= 2)
  parameter int BEEP_TICKS = 3     // beep length in seconds (beeper build only)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  microwave_timer_if.slave   bus
);

  // State encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTRY = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Prescaler sizing; a width of at least one bit keeps TICK_DIV=2 legal
  localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    min_tens_q, min_tens_d;
  logic [3:0]    min_ones_q, min_ones_d;
  logic [3:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    sec_ones_q, sec_ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          timer_done_q, timer_done_d;

  // One-second-down values of the current display
  logic [3:0]    dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;
  logic          dec_zero;
  logic          time_nz;
  logic          entry_ok;
  logic          enter_done;

  // A keypad digit is taken only when valid BCD, magnetron off and not counting
  assign entry_ok = bus.digit_valid && (bus.digit <= 4'd9) && !bus.mag_on &&
                    (state_q != ST_RUN);

  assign time_nz = |{min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};

  // BCD borrow chain: seconds wrap 0->9 / tens 0->5, minutes ones 0->9.
  // Seconds entered above 59 simply count down digit-wise.
  always_comb begin
    dec_min_tens = min_tens_q;
    dec_min_ones = min_ones_q;
    dec_sec_tens = sec_tens_q;
    dec_sec_ones = sec_ones_q;
    if (sec_ones_q != 4'd0) begin
      dec_sec_ones = sec_ones_q - 4'd1;
    end else begin
      dec_sec_ones = 4'd9;
      if (sec_tens_q != 4'd0) begin
        dec_sec_tens = sec_tens_q - 4'd1;
      end else begin
        dec_sec_tens = 4'd5;
        if (min_ones_q != 4'd0) begin
          dec_min_ones = min_ones_q - 4'd1;
        end else begin
          dec_min_ones = 4'd9;
          // From 00:00 the chain never runs (RUN is left on reaching zero),
          // so the top digit simply saturates at 0.
          if (min_tens_q != 4'd0) begin
            dec_min_tens = min_tens_q - 4'd1;
          end
        end
      end
    end
  end

  assign dec_zero = ~|{dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones};

  // Main next-state logic: clear first, then keypad entry, then the FSM
  always_comb begin
    state_d      = state_q;
    min_tens_d   = min_tens_q;
    min_ones_d   = min_ones_q;
    sec_tens_d   = sec_tens_q;
    sec_ones_d   = sec_ones_q;
    presc_d      = presc_q;
    timer_done_d = timer_done_q;

    if (!bus.clearn) begin
      state_d      = ST_IDLE;
      min_tens_d   = 4'd0;
      min_ones_d   = 4'd0;
      sec_tens_d   = 4'd0;
      sec_ones_d   = 4'd0;
      presc_d      = '0;
      timer_done_d = 1'b0;
    end else if (entry_ok) begin
      // New digit enters on the right, display scrolls left
      min_tens_d   = min_ones_q;
      min_ones_d   = sec_tens_q;
      sec_tens_d   = sec_ones_q;
      sec_ones_d   = bus.digit;
      state_d      = ST_ENTRY;
      timer_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ENTRY: begin
          if (bus.mag_on) begin
            if (time_nz) begin
              // Start counting; this edge is not a prescaler cycle
              state_d = ST_RUN;
            end else begin
              // Nothing to cook: report done so the magnetron is shut off
              state_d      = ST_DONE;
              timer_done_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          // mag_on low pauses: prescaler and digits simply hold
          if (bus.mag_on) begin
            if (presc_q == PRESC_LAST) begin
              presc_d    = '0;
              min_tens_d = dec_min_tens;
              min_ones_d = dec_min_ones;
              sec_tens_d = dec_sec_tens;
              sec_ones_d = dec_sec_ones;
              if (dec_zero) begin
                state_d      = ST_DONE;
                timer_done_d = 1'b1;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        ST_DONE: begin
          min_tens_d   = 4'd0;
          min_ones_d   = 4'd0;
          sec_tens_d   = 4'd0;
          sec_ones_d   = 4'd0;
          timer_done_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Pulse on the edge that moves the FSM into DONE
  assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);

  // Timer state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      min_tens_q   <= 4'd0;
      min_ones_q   <= 4'd0;
      sec_tens_q   <= 4'd0;
      sec_ones_q   <= 4'd0;
      presc_q      <= '0;
      timer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_tens_q   <= min_tens_d;
      min_ones_q   <= min_ones_d;
      sec_tens_q   <= sec_tens_d;
      sec_ones_q   <= sec_ones_d;
      presc_q      <= presc_d;
      timer_done_q <= timer_done_d;
    end
  end

`ifdef TIMER_BEEP_EN
  localparam int            BEEP_TOTAL = BEEP_TICKS * TICK_DIV;
  localparam int            BW         = (BEEP_TOTAL > 2) ? $clog2(BEEP_TOTAL) : 1;
  localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_TOTAL - 1);

  logic          beep_q, beep_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;

  // Beeper: loaded on entering DONE, counts down the remaining high cycles
  always_comb begin
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;
    if (!bus.clearn || entry_ok) begin
      beep_d     = 1'b0;
      beep_cnt_d = '0;
    end else if (enter_done) begin
      beep_d     = 1'b1;
      beep_cnt_d = BEEP_LAST;
    end else if (beep_q) begin
      if (beep_cnt_q == '0) begin
        beep_d = 1'b0;
      end else begin
        beep_cnt_d = beep_cnt_q - BW'(1);
      end
    end
  end

  // Beeper registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else begin
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign bus.beep = beep_q;
`else
  // Beeper not built; the DONE-entry pulse has no consumer
  logic unused_enter_done;
  assign unused_enter_done = enter_done;
  assign bus.beep          = 1'b0;
`endif

  assign bus.timer_done = timer_done_q;
  assign bus.min_tens   = min_tens_q;
  assign bus.min_ones   = min_ones_q;
  assign bus.sec_tens   = sec_tens_q;
  assign bus.sec_ones   = sec_ones_q;

endmodule

`default_nettype wire

// File: tb/tb_microwave_timer.sv
//------------------------------------------------------------------------------
// Module   : tb_microwave_timer
// Brief    : Directed self-checking bench for microwave_timer (TICK_DIV=4,
//            BEEP_TICKS=3). Beeper checks follow the TIMER_BEEP_EN build.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_microwave_timer;

  localparam int TICK_DIV   = 4;
  localparam int BEEP_TICKS = 3;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  microwave_timer_if bus ();

  microwave_timer #(
    .TICK_DIV   (TICK_DIV),
    .BEEP_TICKS (BEEP_TICKS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display packed as mm:ss hex nibbles for readable comparisons
  function automatic logic [15:0] disp();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic enter(input logic [3:0] d);
    bus.digit       = d;
    bus.digit_valid = 1'b1;
    tick(1);
    bus.digit_valid = 1'b0;
  endtask

  task automatic do_clear();
    bus.mag_on = 1'b0;
    bus.clearn = 1'b0;
    tick(1);
    bus.clearn = 1'b1;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.clearn      = 1'b1;
    bus.digit       = 4'd7;
    bus.digit_valid = 1'b1;
    bus.mag_on      = 1'b1;
    tick(3);
    checks++;
    if ({disp(), bus.timer_done, bus.beep} !== 18'h0) begin
      failures++;
      $display("FAIL reset_state: got disp=%h done=%b beep=%b expected 0000/0/0", disp(), bus.timer_done, bus.beep);
    end
    bus.digit_valid = 1'b0;
    bus.mag_on      = 1'b0;
    reset           = 1'b0;
    tick(1);
    checks++;
    if ({disp(), bus.timer_done, bus.beep} !== 18'h0) begin
      failures++;
      $display("FAIL reset_release: got disp=%h done=%b beep=%b expected 0000/0/0", disp(), bus.timer_done, bus.beep);
    end
  endtask

  task automatic test_countdown();
    do_clear();
    enter(4'd1);
    enter(4'd0);
    checks++;
    if (disp() !== 16'h0010) begin
      failures++;
      $display("FAIL entry_10: got %h expected 0010", disp());
    end
    bus.mag_on = 1'b1;
    tick(1);              // edge N: ENTRY -> RUN
    tick(3);              // N+3
    checks++;
    if (disp() !== 16'h0010) begin
      failures++;
      $display("FAIL before_first_tick: got %h expected 0010", disp());
    end
    tick(1);              // N+4
    checks++;
    if (disp() !== 16'h0009) begin
      failures++;
      $display("FAIL first_tick: got %h expected 0009", disp());
    end
    tick(35);             // N+39
    checks++;
    if (disp() !== 16'h0001 || bus.timer_done !== 1'b0) begin
      failures++;
      $display("FAIL before_done: got disp=%h done=%b expected 0001/0", disp(), bus.timer_done);
    end
    tick(1);              // N+40
    checks++;
    if (disp() !== 16'h0000 || bus.timer_done !== 1'b1) begin
      failures++;
      $display("FAIL done_at_40: got disp=%h done=%b expected 0000/1", disp(), bus.timer_done);
    end
    bus.mag_on = 1'b0;
    tick(2);
    checks++;
    if (bus.timer_done !== 1'b1) begin
      failures++;
      $display("FAIL done_held: got %b expected 1", bus.timer_done);
    end
  endtask

  task automatic test_borrow();
    do_clear();
    enter(4'd1);
    enter(4'd0);
    enter(4'd0);
    checks++;
    if (disp() !== 16'h0100) begin
      failures++;
      $display("FAIL entry_100: got %h expected 0100", disp());
    end
    bus.mag_on = 1'b1;
    tick(1 + TICK_DIV);
    checks++;
    if (disp() !== 16'h0059) begin
      failures++;
      $display("FAIL minute_borrow: got %h expected 0059", disp());
    end
    do_clear();
    enter(4'd9);
    enter(4'd9);
    bus.mag_on = 1'b1;
    tick(1 + TICK_DIV);
    checks++;
    if (disp() !== 16'h0098) begin
      failures++;
      $display("FAIL sec99_one_tick: got %h expected 0098", disp());
    end
    tick(TICK_DIV);
    checks++;
    if (disp() !== 16'h0097) begin
      failures++;
      $display("FAIL sec99_two_ticks: got %h expected 0097", disp());
    end
  endtask

  task automatic test_pause();
    do_clear();
    enter(4'd1);
    enter(4'd0);
    bus.mag_on = 1'b1;
    tick(1);              // edge N
    tick(6);              // N+6, prescaler mid-count
    bus.mag_on = 1'b0;
    tick(20);             // N+26
    checks++;
    if (disp() !== 16'h0009 || bus.timer_done !== 1'b0) begin
      failures++;
      $display("FAIL pause_hold: got disp=%h done=%b expected 0009/0", disp(), bus.timer_done);
    end
    bus.mag_on = 1'b1;
    tick(1);              // N+27
    checks++;
    if (disp() !== 16'h0009) begin
      failures++;
      $display("FAIL pause_presc_frozen: got %h expected 0009", disp());
    end
    tick(1);              // N+28 = unpaused N+8 shifted by 20
    checks++;
    if (disp() !== 16'h0008) begin
      failures++;
      $display("FAIL pause_resume_tick: got %h expected 0008", disp());
    end
    tick(31);             // N+59
    checks++;
    if (bus.timer_done !== 1'b0) begin
      failures++;
      $display("FAIL pause_done_early: got %b expected 0", bus.timer_done);
    end
    tick(1);              // N+60
    checks++;
    if (bus.timer_done !== 1'b1 || disp() !== 16'h0000) begin
      failures++;
      $display("FAIL pause_done_at_60: got done=%b disp=%h expected 1/0000", bus.timer_done, disp());
    end
  endtask

  task automatic test_boundary();
    do_clear();
    enter(4'hA);
    checks++;
    if (disp() !== 16'h0000) begin
      failures++;
      $display("FAIL digit_A_ignored: got %h expected 0000", disp());
    end
    enter(4'd5);
    enter(4'hF);
    checks++;
    if (disp() !== 16'h0005) begin
      failures++;
      $display("FAIL digit_F_ignored: got %h expected 0005", disp());
    end
    bus.mag_on = 1'b1;
    tick(2);              // RUN, one prescaler cycle in
    bus.mag_on = 1'b0;    // paused but still RUN
    enter(4'd7);
    checks++;
    if (disp() !== 16'h0005) begin
      failures++;
      $display("FAIL entry_in_run_ignored: got %h expected 0005", disp());
    end
    bus.mag_on = 1'b1;
    tick(2);
    bus.clearn = 1'b0;
    tick(1);
    bus.clearn = 1'b1;
    checks++;
    if (disp() !== 16'h0000 || bus.timer_done !== 1'b0) begin
      failures++;
      $display("FAIL clear_in_run: got disp=%h done=%b expected 0000/0", disp(), bus.timer_done);
    end
    // mag_on still high, now IDLE with 00:00 -> DONE on the next edge
    tick(1);
    checks++;
    if (bus.timer_done !== 1'b1 || disp() !== 16'h0000) begin
      failures++;
      $display("FAIL zero_start_done: got done=%b disp=%h expected 1/0000", bus.timer_done, disp());
    end
    bus.mag_on = 1'b0;
    enter(4'd3);
    checks++;
    if (bus.timer_done !== 1'b0 || disp() !== 16'h0003) begin
      failures++;
      $display("FAIL entry_clears_done: got done=%b disp=%h expected 0/0003", bus.timer_done, disp());
    end
  endtask

  task automatic test_beep();
    do_clear();
    enter(4'd1);
    bus.mag_on = 1'b1;
    tick(1 + TICK_DIV);   // edge D: enters DONE
    checks++;
    if (bus.timer_done !== 1'b1) begin
      failures++;
      $display("FAIL beep_setup_done: got %b expected 1", bus.timer_done);
    end
`ifdef TIMER_BEEP_EN
    checks++;
    if (bus.beep !== 1'b1) begin
      failures++;
      $display("FAIL beep_start: got %b expected 1", bus.beep);
    end
    tick(BEEP_TICKS * TICK_DIV - 1);  // D+11
    checks++;
    if (bus.beep !== 1'b1) begin
      failures++;
      $display("FAIL beep_last_cycle: got %b expected 1", bus.beep);
    end
    tick(1);                          // D+12
    checks++;
    if (bus.beep !== 1'b0) begin
      failures++;
      $display("FAIL beep_end: got %b expected 0", bus.beep);
    end
    do_clear();
    enter(4'd1);
    bus.mag_on = 1'b1;
    tick(1 + TICK_DIV);               // D
    bus.mag_on = 1'b0;
    tick(4);                          // D+4
    checks++;
    if (bus.beep !== 1'b1) begin
      failures++;
      $display("FAIL beep_before_entry: got %b expected 1", bus.beep);
    end
    enter(4'd2);                      // sampled at D+5
    checks++;
    if (bus.beep !== 1'b0 || bus.timer_done !== 1'b0) begin
      failures++;
      $display("FAIL beep_entry_stop: got beep=%b done=%b expected 0/0", bus.beep, bus.timer_done);
    end
`else
    tick(2);
    checks++;
    if (bus.beep !== 1'b0) begin
      failures++;
      $display("FAIL beep_disabled: got %b expected 0", bus.beep);
    end
`endif
    bus.mag_on = 1'b0;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    bus.clearn      = 1'b1;
    bus.digit       = 4'd0;
    bus.digit_valid = 1'b0;
    bus.mag_on      = 1'b0;
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_boundary();
    test_beep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
